counter_monitor: RTL and testbench

COUNTER_MONITOR -- requirements
Module: counter_monitor

---
 rtl/counter_monitor_pkg.sv | 33 +++
 rtl/event_fifo.sv | 79 +++++++
 rtl/counter_monitor.sv | 99 +++++++++
 tb/tb_counter_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_monitor_pkg.sv
// Shared types and constants for the counter monitor and its event FIFO.
package counter_monitor_pkg;

  // Sampling state: UNPRIMED has no valid prev yet, ARMED compares against prev.
  typedef enum logic {
    UNPRIMED = 1'b0,
    ARMED    = 1'b1
  } state_t;

  // Width of the dropped-event counter.
  localparam int unsigned DROP_W = 8;

  // Flag bits sit above the count value: {wrap, match, value}.
  localparam int unsigned REC_FLAGS = 2;
  localparam int unsigned MATCH_OFS = 0;
  localparam int unsigned WRAP_OFS  = 1;

  // Total record width for a given count width.
  function automatic int unsigned rec_width(input int unsigned size);
    return size + REC_FLAGS;
  endfunction

  // Bit index of the match flag within a record.
  function automatic int unsigned match_bit(input int unsigned size);
    return size + MATCH_OFS;
  endfunction

  // Bit index of the wrap flag within a record.
  function automatic int unsigned wrap_bit(input int unsigned size);
    return size + WRAP_OFS;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Event record FIFO with a registered valid/ready output port.
// Pushes only land when there is room (or a pop frees a slot in the same
// cycle); a push into an empty FIFO becomes visible on the next cycle.
module event_fifo #(
  parameter int unsigned Width = 7,
  parameter int unsigned Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [Width-1:0] data,
  output logic             full
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic [AddrW-1:0] rd_ptr_next;
  logic [CntW-1:0]  used;
  logic [CntW-1:0]  used_next;
  logic             pop_c;
  logic             wr_c;

  // Handshake decode and next occupancy / read pointer.
  always_comb begin
    pop_c       = valid & ready;
    wr_c        = push & (~full | pop_c);
    used_next   = used + CntW'(wr_c) - CntW'(pop_c);
    rd_ptr_next = pop_c ? rd_ptr + AddrW'(1) : rd_ptr;
  end

  // Record storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
    end else begin
      if (wr_c) begin
        wr_ptr <= wr_ptr + AddrW'(1);
      end
      rd_ptr <= rd_ptr_next;
      used   <= used_next;
      valid  <= (used_next != '0);
      full   <= (used_next == CntW'(Depth));
    end
  end

  // Registered head record; a write landing in the next head slot forwards directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (wr_c && (wr_ptr == rd_ptr_next)) begin
      data <= push_data;
    end else begin
      data <= mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Watches an upstream counter, records wrap and match events into a FIFO,
// and tracks records lost to a full FIFO.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int unsigned Size  = 5,
  parameter int unsigned Depth = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [Size-1:0]   count,
  input  logic              enable,
  input  logic [Size-1:0]   match_value,
  input  logic              clear_overflow,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [Size+1:0]   evt_data,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam int unsigned RecW     = rec_width(Size);
  localparam int unsigned WrapIdx  = wrap_bit(Size);
  localparam int unsigned MatchIdx = match_bit(Size);

  state_t          state;
  logic [Size-1:0] prev;
  logic            wrap_c;
  logic            match_c;
  logic            push_c;
  logic            drop_c;
  logic            fifo_full;
  logic [RecW-1:0] rec_c;

  // Event detection on an enabled sample while armed.
  always_comb begin
    wrap_c  = enable & (state == ARMED) & (prev == '1) & (count == '0);
    match_c = enable & (state == ARMED) & (count == match_value) & (count != prev);
    push_c  = wrap_c | match_c;
    drop_c  = push_c & fifo_full & ~(evt_valid & evt_ready);
  end

  // Record assembly: {wrap, match, sampled count}.
  always_comb begin
    rec_c              = '0;
    rec_c[Size-1:0]    = count;
    rec_c[WrapIdx]     = wrap_c;
    rec_c[MatchIdx]    = match_c;
  end

  // Sampling state machine; prev tracks every enabled sample, even dropped ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= UNPRIMED;
      prev  <= '0;
    end else if (enable) begin
      case (state)
        UNPRIMED: state <= ARMED;
        ARMED:    state <= ARMED;
        default:  state <= UNPRIMED;
      endcase
      prev <= count;
    end
  end

  // Sticky overflow and saturating drop counter; a same-cycle drop wins over clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop_c) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        drop_count <= DROP_W'(1);
      end else if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // Record queue and consumer handshake.
  event_fifo #(
    .Width (RecW),
    .Depth (Depth)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (rec_c),
    .ready     (evt_ready),
    .valid     (evt_valid),
    .data      (evt_data),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench for counter_monitor (Size=5, Depth=4).
module tb_counter_monitor;

  logic       clock;
  logic       reset;
  logic [4:0] count;
  logic       enable;
  logic [4:0] match_value;
  logic       clear_overflow;
  logic       evt_valid;
  logic       evt_ready;
  logic [6:0] evt_data;
  logic       overflow;
  logic [7:0] drop_count;

  counter_monitor #(.Size(5), .Depth(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .count          (count),
    .enable         (enable),
    .match_value    (match_value),
    .clear_overflow (clear_overflow),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [4:0] cnt;
    logic [4:0] mv;
    logic       rdy;
    logic       clr;
    logic       push;
    logic [6:0] rec;
    logic       strict;
  } vec_t;

  typedef struct {
    logic [6:0] rec;
    int         cyc;
    logic       strict;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic add(input logic en, input int cnt, input int mv, input logic rdy,
                     input logic clr, input logic push, input logic [1:0] flags,
                     input logic strict);
    vec_t t;
    t.en     = en;
    t.cnt    = 5'(cnt);
    t.mv     = 5'(mv);
    t.rdy    = rdy;
    t.clr    = clr;
    t.push   = push;
    t.rec    = {flags, 5'(cnt)};
    t.strict = strict;
    tbl.push_back(t);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) add(1'b0, 0, 0, rdy, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  // Compare the visible head against the oldest expected record; retire it on a handshake.
  task automatic check_head(input logic rdy);
    if (evt_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_record: got evt_data=%0h want no record", evt_data);
      end else begin
        check("head_data", 32'(evt_data), 32'(sbq[0].rec));
        if (rdy) begin
          if (sbq[0].strict) check("latency", 32'(cyc - sbq[0].cyc), 32'd1);
          void'(sbq.pop_front());
        end
      end
    end
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    @(negedge clock);
    check_head(t.rdy);
    enable         = t.en;
    count          = t.cnt;
    match_value    = t.mv;
    evt_ready      = t.rdy;
    clear_overflow = t.clr;
    if (t.push) begin
      e.rec    = t.rec;
      e.cyc    = cyc;
      e.strict = t.strict;
      sbq.push_back(e);
    end
    cyc++;
  endtask

  task automatic run(input int from, input int to);
    for (int i = from; i < to; i++) apply(tbl[i]);
  endtask

  task automatic drained(input string name);
    @(negedge clock);
    check({name, "_queue_left"}, 32'(sbq.size()), 32'd0);
    check({name, "_valid"}, 32'(evt_valid), 32'd0);
  endtask

  task automatic flags(input string name, input logic ovf, input int drops);
    @(negedge clock);
    check({name, "_overflow"}, 32'(overflow), 32'(ovf));
    check({name, "_drop_count"}, 32'(drop_count), 32'(drops));
    enable         = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s1, s2, s3, s4, s5, s6, s7, s8, s9, s10;
    clock = 1'b0; reset = 1'b0; enable = 1'b0; count = '0; match_value = '0;
    clear_overflow = 1'b0; evt_ready = 1'b0;

    // Wrap 29..0, held-count match, wrap+match together.
    add(1, 29, 7, 1, 0, 0, 2'b00, 0);
    add(1, 30, 7, 1, 0, 0, 2'b00, 0);
    add(1, 31, 7, 1, 0, 0, 2'b00, 0);
    add(1,  0, 7, 1, 0, 1, 2'b10, 1);
    idle(3, 1);
    add(1, 5, 7, 1, 0, 0, 2'b00, 0);
    add(1, 6, 7, 1, 0, 0, 2'b00, 0);
    add(1, 7, 7, 1, 0, 1, 2'b01, 1);
    add(1, 7, 7, 1, 0, 0, 2'b00, 0);
    add(1, 7, 7, 1, 0, 0, 2'b00, 0);
    idle(3, 1);
    add(1, 30, 0, 1, 0, 0, 2'b00, 0);
    add(1, 31, 0, 1, 0, 0, 2'b00, 0);
    add(1,  0, 0, 1, 0, 1, 2'b11, 1);
    idle(3, 1);
    s1 = tbl.size();
    // Six matches into a stalled consumer: four kept, two dropped.
    for (int k = 1; k <= 6; k++) add(1, k, k, 0, 0, (k <= 4), 2'b01, 0);
    s2 = tbl.size();
    idle(6, 1);
    s3 = tbl.size();
    // Fill, then push and pop together while full.
    for (int k = 10; k <= 13; k++) add(1, k, k, 0, 0, 1, 2'b01, 0);
    add(1, 14, 14, 1, 0, 1, 2'b01, 0);
    idle(1, 0);
    s4 = tbl.size();
    idle(6, 1);
    s5 = tbl.size();
    add(0, 0, 0, 1, 1, 0, 2'b00, 0);
    s6 = tbl.size();
    // Fill, then drop in the same cycle as clear_overflow.
    for (int k = 20; k <= 23; k++) add(1, k, k, 0, 0, 1, 2'b01, 0);
    add(1, 24, 24, 0, 1, 0, 2'b00, 0);
    s7 = tbl.size();
    idle(6, 1);
    s8 = tbl.size();
    // Three records queued ahead of a mid-run reset.
    for (int k = 1; k <= 3; k++) add(1, k, k, 0, 0, 1, 2'b01, 0);
    s9 = tbl.size();
    // After reset: first sample only primes, the next one detects.
    add(1, 7, 7, 1, 0, 0, 2'b00, 0);
    idle(2, 1);
    add(1, 8, 8, 1, 0, 1, 2'b01, 1);
    idle(2, 1);
    s10 = tbl.size();

    #1;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_release_valid", 32'(evt_valid), 32'd0);

    run(0, s1);
    drained("wrap_match");
    run(s1, s2);
    flags("six_events", 1'b1, 2);
    run(s2, s3);
    drained("drain_four");
    run(s3, s4);
    flags("full_push_pop", 1'b1, 2);
    run(s4, s5);
    drained("full_push_pop_drain");
    run(s5, s6);
    flags("clear", 1'b0, 0);
    run(s6, s7);
    flags("drop_with_clear", 1'b1, 1);
    run(s7, s8);
    drained("drop_with_clear_drain");
    run(s8, s9);

    @(negedge clock);
    enable = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", 32'(evt_valid), 32'd0);
    check("midrst_data", 32'(evt_data), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
    sbq.delete();
    @(negedge clock);
    reset = 1'b1;
    run(s9, s10);
    drained("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
